blink_sequencer: RTL and testbench
==================================

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_i and rst_i.
REQ-002 Parameter CNT_WIDTH SHALL default to 24 and set the width of the per-phase tick counter and period_i.
REQ-003 Parameter NUM_WIDTH SHALL default to 4 and set the width of the blink-count input count_i.
REQ-004 clk_i  input  1  rising-edge clock for all state.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 start_i  input  1  request to start a sequence; sampled on each clk_i edge.
REQ-007 stop_i  input  1  abort request; sampled on each clk_i edge.
REQ-008 count_i  input  NUM_WIDTH  number of blinks N; latched when start_i is accepted.
REQ-009 period_i  input  CNT_WIDTH  on-time and off-time in cycles P; latched when start_i is accepted.
REQ-010 blink_o  output  1  registered LED drive.
REQ-011 busy_o  output  1  registered; high while blinks are in progress.
REQ-012 done_o  output  1  registered one-cycle pulse at normal sequence completion.

Function
REQ-013 FSM states SHALL be IDLE, ON, OFF and DONE.
REQ-014 In IDLE, start_i=1 with stop_i=0 SHALL be accepted and SHALL latch N=count_i and P=max(period_i,1); period_i=0 is treated as 1.
REQ-015 An accepted start with N>=1 SHALL enter ON on that edge, so blink_o=1 and busy_o=1 from the next cycle.
REQ-016 An accepted start with N=0 SHALL go directly to DONE: no blink_o pulse, and busy_o stays 0.
REQ-017 ON SHALL last exactly P cycles with blink_o=1, then go to OFF.
REQ-018 OFF SHALL last exactly P cycles with blink_o=0; after OFF, the FSM SHALL go to ON if blinks remain, else to DONE.
REQ-019 A full sequence SHALL produce exactly N blink_o pulses, each P cycles high and followed by P cycles low (2*N*P busy cycles).
REQ-020 DONE SHALL last exactly one cycle, with done_o=1, busy_o=0 and blink_o=0, then go to IDLE.
REQ-021 start_i SHALL be ignored in ON, OFF and DONE; latched N and P SHALL NOT change mid-sequence.
REQ-022 stop_i=1 in ON or OFF SHALL force IDLE on that edge: blink_o=0 and busy_o=0 next cycle, and no done_o pulse.
REQ-023 When start_i and stop_i are both high in IDLE, stop_i SHALL win and no sequence starts.
REQ-024 stop_i in DONE SHALL NOT suppress the done_o pulse.
REQ-025 The tick counter SHALL count 0..P-1 per phase and SHALL NOT wrap beyond P-1, including at P=2^CNT_WIDTH-1.
REQ-026 Remaining-blink arithmetic SHALL use NUM_WIDTH bits with no underflow: N=2^NUM_WIDTH-1 SHALL yield exactly that many blinks.

Reset
REQ-027 rst_i=1 SHALL immediately force IDLE, blink_o=0, busy_o=0 and done_o=0, and clear the tick counter, remaining count and latched P, independent of clk_i.
REQ-028 rst_i asserted mid-sequence SHALL abort without a done_o pulse; after release the block SHALL wait in IDLE for a new start_i.

Configuration
REQ-029 Macro BLINK_SEQ_REPEAT_EN SHALL control an extra input port repeat_i (1 bit).
REQ-030 With BLINK_SEQ_REPEAT_EN defined:
- repeat_i=1 sampled on the last OFF cycle SHALL send the FSM from OFF to ON with the latched N and P reloaded, instead of going to DONE.
- done_o SHALL still pulse for one cycle at each round boundary, and busy_o SHALL stay 1.
- stop_i SHALL end repetition.
REQ-031 Without BLINK_SEQ_REPEAT_EN, repeat_i SHALL NOT exist and behaviour SHALL be exactly REQ-013..REQ-028.

Verification
REQ-032 count_i=3, period_i=4, start_i pulse -> three blink_o pulses of 4 cycles high and 4 low; busy_o high for 24 cycles; done_o single pulse in cycle 25.
REQ-033 count_i=0, period_i=10, start_i -> blink_o never high, busy_o stays 0, done_o pulses in the cycle after start.
REQ-034 period_i=0, count_i=2 -> blink_o pattern 1,0,1,0, then done_o.
REQ-035 count_i=5, period_i=3; stop_i asserted during 2nd ON; and separately start_i=stop_i=1 in IDLE -> blink_o=0 and busy_o=0 next cycle, with no done_o; simultaneous start and stop does not start.
REQ-036 rst_i asserted mid-OFF, asynchronous to clk_i -> outputs 0 immediately; start_i after release, with count_i=1 and period_i=2 -> clean single 2-cycle pulse.
REQ-037 With BLINK_SEQ_REPEAT_EN and repeat_i=1, count_i=1, period_i=2 -> continuous 1,1,0,0 pattern, done_o every 4 cycles, busy_o stays 1; then stop_i -> IDLE.

Source files
------------

// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - N-pulse LED blink sequencer with P-cycle on/off phases.
// Optional macro BLINK_SEQ_REPEAT_EN adds repeat_i for back-to-back rounds.
module blink_sequencer #(
  parameter int CNT_WIDTH = 24,
  parameter int NUM_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [NUM_WIDTH-1:0] count_i,
  input  logic [CNT_WIDTH-1:0] period_i,
`ifdef BLINK_SEQ_REPEAT_EN
  input  logic                 repeat_i,
`endif
  output logic                 blink_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [NUM_WIDTH-1:0] NUM_ONE = NUM_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] tick_q;
  logic [CNT_WIDTH-1:0] p_q;
  logic [NUM_WIDTH-1:0] rem_q;
  logic                 start_ok, phase_end, last_blink, repeat_req, round_end;
  logic                 blink_d, busy_d, done_d;

`ifdef BLINK_SEQ_REPEAT_EN
  logic [NUM_WIDTH-1:0] n_q;
  assign repeat_req = repeat_i;
`else
  assign repeat_req = 1'b0;
`endif

  assign start_ok   = (state_q == S_IDLE) && start_i && !stop_i;
  assign phase_end  = (tick_q == p_q - CNT_ONE);
  assign last_blink = (rem_q <= NUM_ONE);
  // End of the final OFF phase of a round, not cut short by stop_i.
  assign round_end  = (state_q == S_OFF) && phase_end && last_blink && !stop_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      blink_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_o <= blink_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = (count_i == '0) ? S_DONE : S_ON;
      S_ON: begin
        if (stop_i)         state_d = S_IDLE;
        else if (phase_end) state_d = S_OFF;
      end
      S_OFF: begin
        if (stop_i)                          state_d = S_IDLE;
        else if (phase_end && !last_blink)   state_d = S_ON;
        else if (phase_end && repeat_req)    state_d = S_ON;
        else if (phase_end)                  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    blink_d = (state_d == S_ON);
    busy_d  = (state_d == S_ON) || (state_d == S_OFF);
    done_d  = (state_d == S_DONE) || round_end;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q <= '0;
      p_q    <= '0;
      rem_q  <= '0;
`ifdef BLINK_SEQ_REPEAT_EN
      n_q    <= '0;
`endif
    end else if (start_ok) begin
      tick_q <= '0;
      rem_q  <= count_i;
      p_q    <= (period_i == '0) ? CNT_ONE : period_i;
`ifdef BLINK_SEQ_REPEAT_EN
      n_q    <= count_i;
`endif
    end else if (state_q == S_ON || state_q == S_OFF) begin
      if (phase_end) begin
        tick_q <= '0;
        if (state_q == S_OFF && !last_blink) rem_q <= rem_q - NUM_ONE;
`ifdef BLINK_SEQ_REPEAT_EN
        else if (state_q == S_OFF && repeat_req) rem_q <= n_q;
`endif
      end else begin
        tick_q <= tick_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb/tb_blink_sequencer.sv - directed self-checking bench for blink_sequencer.
module tb_blink_sequencer;

  localparam int CW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_r, stop_r;
  logic [NW-1:0] count_r;
  logic [CW-1:0] period_r;
`ifdef BLINK_SEQ_REPEAT_EN
  logic          repeat_r;
`endif
  logic          blink, busy, done;

  int checks   = 0;
  int failures = 0;

  blink_sequencer #(.CNT_WIDTH(CW), .NUM_WIDTH(NW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start_r),
    .stop_i   (stop_r),
    .count_i  (count_r),
    .period_i (period_r),
`ifdef BLINK_SEQ_REPEAT_EN
    .repeat_i (repeat_r),
`endif
    .blink_o  (blink),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference waveform: bit k is the value seen k cycles after the start edge.
  task automatic expect_seq(input int n, input int p, input int cycles,
                            output logic [63:0] eb, output logic [63:0] eu,
                            output logic [63:0] ed);
    int pe, tot;
    pe = (p == 0) ? 1 : p;
    tot = 2 * n * pe;
    eb = '0; eu = '0; ed = '0;
    for (int k = 1; k <= cycles; k++) begin
      eb[k] = (k <= tot) && ((((k - 1) / pe) % 2) == 0);
      eu[k] = (k <= tot);
      ed[k] = (k == tot + 1);
    end
  endtask

  task automatic run_seq(input int n, input int p, input int cycles, input int restart_at,
                         output logic [63:0] bv, output logic [63:0] uv,
                         output logic [63:0] dv);
    bv = '0; uv = '0; dv = '0;
    @(negedge clk);
    start_r = 1'b1; count_r = NW'(n); period_r = CW'(p);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      bv[k] = blink; uv[k] = busy; dv[k] = done;
      start_r = (k == restart_at);
      if (k == restart_at) begin
        count_r = 4'd7; period_r = 4'd1;
      end
    end
    start_r = 1'b0;
  endtask

  task automatic seq_case(input string tag, input int n, input int p, input int cycles,
                          input int restart_at);
    logic [63:0] bv, uv, dv, eb, eu, ed;
    run_seq(n, p, cycles, restart_at, bv, uv, dv);
    expect_seq(n, p, cycles, eb, eu, ed);
    check({tag, "_blink"}, bv, eb);
    check({tag, "_busy"}, uv, eu);
    check({tag, "_done"}, dv, ed);
  endtask

  initial begin
    logic done_seen;
    rst = 1'b1; start_r = 1'b0; stop_r = 1'b0; count_r = '0; period_r = '0;
`ifdef BLINK_SEQ_REPEAT_EN
    repeat_r = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_blink", 64'(blink), 64'd0);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_done",  64'(done),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    seq_case("n3_p4",     3, 4, 30, 0);
    seq_case("n0_p10",    0, 10, 5, 0);
    seq_case("n2_p0",     2, 0, 6, 0);
    seq_case("n15_p1",   15, 1, 34, 0);
    seq_case("n1_p15",    1, 15, 33, 0);
    seq_case("restart_ignored", 2, 2, 12, 3);

    // Stop in the second ON phase (cycles 7..9 for P=3).
    done_seen = 1'b0;
    @(negedge clk);
    start_r = 1'b1; count_r = 4'd5; period_r = 4'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start_r = 1'b0;
      done_seen = done_seen | done;
      if (k == 7) begin
        check("stop_pre_blink", 64'(blink), 64'd1);
        stop_r = 1'b1;
      end
      if (k == 8) begin
        check("stop_blink", 64'(blink), 64'd0);
        check("stop_busy",  64'(busy),  64'd0);
        stop_r = 1'b0;
      end
    end
    check("stop_no_done", 64'(done_seen), 64'd0);
    check("stop_stays_idle", 64'(busy | blink), 64'd0);

    // Start and stop together in IDLE must not start.
    done_seen = 1'b0;
    start_r = 1'b1; stop_r = 1'b1; count_r = 4'd2; period_r = 4'd1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_r = 1'b0; stop_r = 1'b0;
      done_seen = done_seen | done | busy | blink;
    end
    check("start_stop_idle", 64'(done_seen), 64'd0);

    // Asynchronous reset in the middle of an OFF phase.
    start_r = 1'b1; count_r = 4'd3; period_r = 4'd4;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start_r = 1'b0;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy",  64'(busy),  64'd0);
    check("async_rst_blink", 64'(blink), 64'd0);
    check("async_rst_done",  64'(done),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    seq_case("post_rst_n1_p2", 1, 2, 6, 0);

`ifdef BLINK_SEQ_REPEAT_EN
    begin
      logic [63:0] bv, uv, dv, eb, eu, ed;
      bv = '0; uv = '0; dv = '0; eb = '0; eu = '0; ed = '0;
      repeat_r = 1'b1;
      start_r = 1'b1; count_r = 4'd1; period_r = 4'd2;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        start_r = 1'b0;
        bv[k] = blink; uv[k] = busy; dv[k] = done;
        eb[k] = ((k % 4) == 1) || ((k % 4) == 2);
        eu[k] = 1'b1;
        ed[k] = (k > 1) && ((k % 4) == 1);
      end
      check("rpt_blink", bv, eb);
      check("rpt_busy",  uv, eu);
      check("rpt_done",  dv, ed);
      stop_r = 1'b1;
      @(negedge clk);
      stop_r = 1'b0; repeat_r = 1'b0;
      check("rpt_stop", {61'd0, blink, busy, done}, 64'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
